// File: rtl/escalator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | escalator_pkg                                                      |
// | Shared floor encodings, scheduler states and one-hot helpers.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package escalator_pkg;

    typedef logic [3:0] floor_t;

    localparam floor_t FLOOR_0 = 4'b0001;
    localparam floor_t FLOOR_1 = 4'b0010;
    localparam floor_t FLOOR_2 = 4'b0100;
    localparam floor_t FLOOR_3 = 4'b1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_t;

    function automatic logic is_onehot(input floor_t v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic floor_t lowest_bit(input floor_t v);
        return v & (~v + 4'd1);
    endfunction

    function automatic floor_t highest_bit(input floor_t v);
        floor_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // pf is assumed one-hot: (pf - 1) is exactly the set of floors below it
    function automatic floor_t above_mask(input floor_t pend, input floor_t pf);
        return pend & ~(pf | (pf - 4'd1));
    endfunction

    function automatic floor_t below_mask(input floor_t pend, input floor_t pf);
        return pend & (pf - 4'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/call_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | call_sync_edge                                                     |
// | Two-flop synchronizer per bit followed by rising-edge detect.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module call_sync_edge #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_btn,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_rise = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/floor_call_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | floor_call_scheduler                                               |
// | Latches floor calls and serves them in SCAN order with door dwell. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module floor_call_scheduler
    import escalator_pkg::*;
#(
    parameter int DWELL_TICKS = 3,
    parameter int N_FLOORS    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] call_btn,
    input  logic [N_FLOORS-1:0] present_floor,
    input  logic                tick,
    output logic [N_FLOORS-1:0] requested_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open,
    output logic                dir_up,
    output logic                busy
);

    localparam int                 c_cnt_w = $clog2(DWELL_TICKS + 1);
    localparam logic [c_cnt_w-1:0] c_dwell = c_cnt_w'(DWELL_TICKS);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] w_pending_nxt;
    logic [N_FLOORS-1:0] r_req_last;
    logic [N_FLOORS-1:0] w_req;
    logic [N_FLOORS-1:0] w_press;
    logic [N_FLOORS-1:0] w_above;
    logic [N_FLOORS-1:0] w_below;
    logic [N_FLOORS-1:0] w_near_up;
    logic [N_FLOORS-1:0] w_near_dn;
    logic [N_FLOORS-1:0] w_set;
    logic [N_FLOORS-1:0] w_clr;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic                r_dir_up;
    logic                w_dir_nxt;
    logic                r_door;
    logic                w_door_nxt;
    logic                w_valid;
    logic                w_at_call;
    logic                w_enter_door;

    call_sync_edge #(
        .WIDTH (N_FLOORS)
    ) u_call_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (call_btn),
        .o_rise (w_press)
    );

    assign w_valid   = is_onehot(present_floor);
    assign w_above   = above_mask(r_pending, present_floor);
    assign w_below   = below_mask(r_pending, present_floor);
    assign w_near_up = lowest_bit(w_above);
    assign w_near_dn = highest_bit(w_below);
    assign w_at_call = |(r_pending & present_floor);

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir_up;
        w_door_nxt   = r_door;
        w_cnt_nxt    = r_cnt;
        w_enter_door = 1'b0;
        w_req        = present_floor;

        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    if (w_at_call) begin
                        w_enter_door = 1'b1;
                    end else if (|w_above) begin
                        w_state_nxt = MOVE_UP;
                        w_dir_nxt   = 1'b1;
                    end else if (|w_below) begin
                        w_state_nxt = MOVE_DN;
                        w_dir_nxt   = 1'b0;
                    end
                end
            end
            MOVE_UP: begin
                w_req = (|w_above) ? w_near_up : present_floor;
                if (w_valid) begin
                    if (w_at_call)
                        w_enter_door = 1'b1;
                    else if (!(|w_above))
                        w_state_nxt = IDLE;
                end
            end
            MOVE_DN: begin
                w_req = (|w_below) ? w_near_dn : present_floor;
                if (w_valid) begin
                    if (w_at_call)
                        w_enter_door = 1'b1;
                    else if (!(|w_below))
                        w_state_nxt = IDLE;
                end
            end
            DOOR: begin
                if (w_valid) begin
                    // A fresh press at the open floor keeps the door open instead of queueing
                    if (|(w_press & present_floor)) begin
                        w_cnt_nxt = c_dwell;
                    end else if (tick) begin
                        if (r_cnt == c_one) begin
                            w_door_nxt = 1'b0;
                            if (r_dir_up) begin
                                if (|w_above) begin
                                    w_state_nxt = MOVE_UP;
                                end else if (|w_below) begin
                                    w_state_nxt = MOVE_DN;
                                    w_dir_nxt   = 1'b0;
                                end else begin
                                    w_state_nxt = IDLE;
                                end
                            end else begin
                                if (|w_below) begin
                                    w_state_nxt = MOVE_DN;
                                end else if (|w_above) begin
                                    w_state_nxt = MOVE_UP;
                                    w_dir_nxt   = 1'b1;
                                end else begin
                                    w_state_nxt = IDLE;
                                end
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - c_one;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_enter_door) begin
            w_state_nxt = DOOR;
            w_cnt_nxt   = c_dwell;
            w_door_nxt  = 1'b1;
        end
    end

    // Clear of the served floor overrides any simultaneous press there
    assign w_set         = w_press & ~(((r_state == DOOR) && w_valid) ? present_floor : '0);
    assign w_clr         = w_enter_door ? present_floor : '0;
    assign w_pending_nxt = (r_pending | w_set) & ~w_clr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_req_last <= FLOOR_0;
            r_door     <= 1'b0;
            r_dir_up   <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_req_last <= requested_floor;
            r_door     <= w_door_nxt;
            r_dir_up   <= w_dir_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // An invalid floor reading freezes the target at its last presented value
    assign requested_floor = w_valid ? w_req : r_req_last;
    assign pending         = r_pending;
    assign door_open       = r_door;
    assign dir_up          = r_dir_up;
    assign busy            = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_floor_call_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_floor_call_scheduler                                            |
// | Table vectors, directed sequences and random traffic vs a model.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_floor_call_scheduler;
    import escalator_pkg::*;

    localparam int DWELL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] call_btn;
    logic [3:0] present_floor;
    logic       tick;
    logic [3:0] requested_floor;
    logic [3:0] pending;
    logic       door_open;
    logic       dir_up;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    floor_call_scheduler #(
        .DWELL_TICKS (DWELL),
        .N_FLOORS    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .call_btn        (call_btn),
        .present_floor   (present_floor),
        .tick            (tick),
        .requested_floor (requested_floor),
        .pending         (pending),
        .door_open       (door_open),
        .dir_up          (dir_up),
        .busy            (busy)
    );

    // Reference model: floors as integers, modes as plain numbers
    localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3;
    int         m_mode;
    logic [3:0] m_pend;
    logic       m_dir;
    logic       m_door;
    int         m_dwell;
    int         m_last;
    logic [3:0] h1, h2, h3;   // button samples taken 1, 2 and 3 edges ago

    function automatic int floor_of(input logic [3:0] pf);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < 4; i++) if (pf[i]) begin n++; idx = i; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int next_up(input int pos);
        for (int i = pos + 1; i < 4; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic int next_dn(input int pos);
        for (int i = pos - 1; i >= 0; i--) if (m_pend[i]) return i;
        return -1;
    endfunction

    function automatic int m_target(input int pos);
        int t;
        if (pos < 0) return m_last;
        t = pos;
        if (m_mode == M_UP && next_up(pos) >= 0) t = next_up(pos);
        if (m_mode == M_DN && next_dn(pos) >= 0) t = next_dn(pos);
        return t;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = 4'b0000; m_dir = 1'b1; m_door = 1'b0;
        m_dwell = 0; m_last = 0; h1 = 4'b0; h2 = 4'b0; h3 = 4'b0;
    endtask

    task automatic model_edge();
        int pos, up, dn, tgt;
        logic enter;
        logic [3:0] rise, set_m;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pos   = floor_of(present_floor);
        rise  = h2 & ~h3;
        tgt   = m_target(pos);
        enter = 1'b0;
        set_m = rise;
        if (pos >= 0) begin
            up = next_up(pos);
            dn = next_dn(pos);
            if (m_mode == M_DOOR) begin
                set_m[pos] = 1'b0;
                if (rise[pos]) m_dwell = DWELL;
                else if (tick) begin
                    if (m_dwell == 1) begin
                        m_door = 1'b0;
                        if (m_dir && up >= 0) m_mode = M_UP;
                        else if (!m_dir && dn >= 0) m_mode = M_DN;
                        else if (up >= 0) begin m_mode = M_UP; m_dir = 1'b1; end
                        else if (dn >= 0) begin m_mode = M_DN; m_dir = 1'b0; end
                        else m_mode = M_IDLE;
                    end else m_dwell--;
                end
            end else if (m_pend[pos]) enter = 1'b1;
            else if (m_mode == M_IDLE) begin
                if (up >= 0) begin m_mode = M_UP; m_dir = 1'b1; end
                else if (dn >= 0) begin m_mode = M_DN; m_dir = 1'b0; end
            end else if (m_mode == M_UP && up < 0) m_mode = M_IDLE;
            else if (m_mode == M_DN && dn < 0) m_mode = M_IDLE;
        end
        m_pend = m_pend | set_m;
        if (enter) begin
            m_pend[pos] = 1'b0;
            m_mode = M_DOOR; m_dwell = DWELL; m_door = 1'b1;
        end
        h3 = h2; h2 = h1; h1 = call_btn;
        m_last = tgt;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_req", requested_floor, onehot(m_target(floor_of(present_floor))));
        check("model_pending", pending, m_pend);
        check("model_door", {3'b000, door_open}, {3'b000, m_door});
        check("model_dir", {3'b000, dir_up}, {3'b000, m_dir});
        check("model_busy", {3'b000, busy}, {3'b000, (m_mode != M_IDLE)});
    endtask

    task automatic do_reset(input logic [3:0] pf);
        present_floor = pf; call_btn = 4'b0; tick = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
    endtask

    typedef struct {
        logic [3:0] pf;
        logic [3:0] exp_req;
        logic       exp_busy;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos_env, move_cnt, tgt;
        int hold [4];

        model_reset();
        rst_n = 1'b0; call_btn = 4'b0; present_floor = FLOOR_0; tick = 1'b0;

        // Idle with no calls: target follows a valid floor and holds on an invalid one
        vecs[0] = '{FLOOR_0, FLOOR_0, 1'b0};
        vecs[1] = '{FLOOR_2, FLOOR_2, 1'b0};
        vecs[2] = '{4'b0000, FLOOR_2, 1'b0};
        vecs[3] = '{4'b1100, FLOOR_2, 1'b0};
        vecs[4] = '{FLOOR_3, FLOOR_3, 1'b0};
        vecs[5] = '{FLOOR_1, FLOOR_1, 1'b0};
        vecs[6] = '{4'b1111, FLOOR_1, 1'b0};

        do_reset(FLOOR_0);
        check("rst_req", requested_floor, 4'b0001);
        check("rst_pending", pending, 4'b0000);
        check("rst_busy", {3'b0, busy}, 4'b0000);
        check("rst_door", {3'b0, door_open}, 4'b0000);
        check("rst_dir", {3'b0, dir_up}, 4'b0001);

        for (int i = 0; i < 7; i++) begin
            present_floor = vecs[i].pf;
            cyc();
            check("tbl_req", requested_floor, vecs[i].exp_req);
            check("tbl_busy", {3'b0, busy}, {3'b0, vecs[i].exp_busy});
        end

        // Trip from floor 0 to floor 3
        do_reset(FLOOR_0);
        call_btn = FLOOR_3;
        cyc(); cyc();
        check("A_lat_e2", pending, 4'b0000);
        cyc();
        check("A_lat_e3", pending, 4'b1000);
        cyc();
        check("A_busy", {3'b0, busy}, 4'b0001);
        check("A_req", requested_floor, 4'b1000);
        cyc();
        call_btn = 4'b0;
        present_floor = FLOOR_1; repeat (3) cyc();
        present_floor = FLOOR_2; repeat (3) cyc();
        present_floor = FLOOR_3; cyc();
        check("A_door", {3'b0, door_open}, 4'b0001);
        check("A_clear", pending, 4'b0000);
        check("A_door_req", requested_floor, 4'b1000);
        pulse_tick(); pulse_tick();
        check("A_dwell2", {3'b0, door_open}, 4'b0001);
        pulse_tick();
        check("A_closed", {3'b0, door_open}, 4'b0000);
        check("A_idle", {3'b0, busy}, 4'b0000);

        // Nearer call retargets and is served on the way
        do_reset(FLOOR_0);
        call_btn = FLOOR_3; repeat (4) cyc();
        check("B_req3", requested_floor, 4'b1000);
        call_btn = 4'b1010; cyc(); cyc();
        check("B_req_pre", requested_floor, 4'b1000);
        cyc();
        check("B_retarget", requested_floor, 4'b0010);
        call_btn = 4'b0;
        present_floor = FLOOR_1; cyc();
        check("B_door", {3'b0, door_open}, 4'b0001);
        check("B_pending", pending, 4'b1000);
        repeat (3) pulse_tick();
        check("B_resume", requested_floor, 4'b1000);
        check("B_busy", {3'b0, busy}, 4'b0001);
        check("B_dir", {3'b0, dir_up}, 4'b0001);

        // Serve the top call, then reverse to the bottom one
        do_reset(FLOOR_2);
        call_btn = FLOOR_3; repeat (4) cyc();
        call_btn = 4'b1001; repeat (3) cyc();
        check("C_pending", pending, 4'b1001);
        check("C_req", requested_floor, 4'b1000);
        call_btn = 4'b0;
        present_floor = FLOOR_3; cyc();
        check("C_pend_after", pending, 4'b0001);
        repeat (3) pulse_tick();
        check("C_dir", {3'b0, dir_up}, 4'b0000);
        check("C_req_dn", requested_floor, 4'b0001);
        check("C_busy", {3'b0, busy}, 4'b0001);

        // Press at the open floor reloads the dwell
        do_reset(FLOOR_1);
        call_btn = FLOOR_1; repeat (4) cyc();
        call_btn = 4'b0;
        check("D_door", {3'b0, door_open}, 4'b0001);
        pulse_tick(); pulse_tick();
        call_btn = FLOOR_1; repeat (3) cyc();
        call_btn = 4'b0;
        check("D_no_pend", pending, 4'b0000);
        pulse_tick(); pulse_tick();
        check("D_reloaded", {3'b0, door_open}, 4'b0001);
        pulse_tick();
        check("D_closed", {3'b0, door_open}, 4'b0000);

        // Invalid floor blocks transitions; reset mid-travel drops calls
        do_reset(4'b0000);
        call_btn = FLOOR_2; repeat (3) cyc();
        call_btn = 4'b0; repeat (3) cyc();
        check("E_pending", pending, 4'b0100);
        check("E_busy", {3'b0, busy}, 4'b0000);
        check("E_req_hold", requested_floor, 4'b0001);
        present_floor = FLOOR_0; cyc();
        check("E_move", {3'b0, busy}, 4'b0001);
        check("E_req", requested_floor, 4'b0100);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        check("E_rst_pend", pending, 4'b0000);
        check("E_rst_req", requested_floor, 4'b0001);
        check("E_rst_busy", {3'b0, busy}, 4'b0000);

        // Random traffic: the car moves one floor every few cycles toward the model's target
        do_reset(FLOOR_0);
        pos_env = 0; move_cnt = 0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if ($urandom_range(0, 24) == 0) hold[i] = int'($urandom_range(1, 8));
                call_btn[i] = (hold[i] > 0);
            end
            tick = ($urandom_range(0, 5) == 0);
            tgt = m_target(pos_env);
            if (!m_door && tgt != pos_env) begin
                move_cnt++;
                if (move_cnt >= 4) begin
                    pos_env = pos_env + ((tgt > pos_env) ? 1 : -1);
                    move_cnt = 0;
                end
            end else move_cnt = 0;
            present_floor = onehot(pos_env);
            if ($urandom_range(0, 79) == 0) present_floor = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110;
            rst_n = ($urandom_range(0, 599) != 0);
            cyc();
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floor_call_scheduler.md
Name: floor_call_scheduler

Overview:
- Upstream stage of the floor controller: collects asynchronous floor-call buttons, latches them as pending calls, and drives the one-hot requested_floor the controller steps toward.
- Uses SCAN ordering (serve calls in the current travel direction before reversing).
- Holds the car at a served floor for a door dwell.
- Consumes the controller's one-hot present_floor and the shared one-second tick.

Parameters:
- DWELL_TICKS, 3: door-open dwell length in tick pulses (minimum 1).
- N_FLOORS, 4: floor count; fixed at 4, one-hot encoding.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- call_btn  input  4  raw asynchronous floor-call buttons, bit i = floor i, level-high while pressed
- present_floor  input  4  one-hot current floor from the controller
- tick  input  1  one-cycle pulse from the one-second timer
- requested_floor  output  4  one-hot target floor presented to the controller
- pending  output  4  latched outstanding calls
- door_open  output  1  high while dwelling at a served floor
- dir_up  output  1  last/current travel direction, 1 = up
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, pending = 0000, requested_floor = 0001, door_open = 0, dir_up = 1, dwell counter = 0.
  - Synchronizer and edge-detect flops cleared.
- Input path:
  - 2-flop synchronizer per bit, then rising-edge detect (sync2 & ~prev).
  - A press sets its pending bit on the 3rd clk edge after the level is first sampled high.
  - Holding a button generates one edge only.
- present_floor validity:
  - Only an exactly one-hot value is valid.
  - While it is invalid: no pending bit is cleared, no state transition occurs, and requested_floor holds its value.
- Target selection:
  - above = pending bits strictly above present_floor; below = pending bits strictly below.
  - nearest_up = lowest set bit of above; nearest_dn = highest set bit of below.
- IDLE:
  - requested_floor = present_floor.
  - If the pending bit at present_floor is set: go to DOOR.
  - Else if above != 0: go to MOVE_UP, dir_up = 1.
  - Else if below != 0: go to MOVE_DN, dir_up = 0.
- MOVE_UP:
  - requested_floor = nearest_up, re-evaluated every cycle, so a new nearer call retargets on the next cycle.
  - When the pending bit at present_floor is set: go to DOOR.
  - If above and the present bit both become 0: go to IDLE.
- MOVE_DN: mirror of MOVE_UP, using nearest_dn.
- Entry to DOOR:
  - On the transition edge: clear the pending bit at present_floor, load the dwell counter with DWELL_TICKS, set door_open = 1.
- DOOR:
  - requested_floor = present_floor; counter decrements on each tick.
  - A new press at present_floor reloads the counter and does not set pending.
  - Exit on the edge where the counter is 1 and tick is high; door_open = 0 from that edge.
  - Exit priority: continue in dir_up direction if calls remain that way; else reverse if calls remain the other way; else IDLE.
- Simultaneous events:
  - Press at floor X in the same cycle as the DOOR-entry clear of X: clear wins, pending[X] stays 0.
  - Presses on other floors in any cycle are always latched.
- Pass-through: an intermediate floor with a pending call in the travel direction becomes nearest_up/dn, so the car stops there.
- Reset mid-operation: everything returns to the reset values on the next edge, and all calls are lost.
- All outputs are registered except requested_floor and busy, which are combinational from registered state, pending, and present_floor.

Decomposition:
- Package escalator_pkg:
  - Floor one-hot constants FLOOR_0=0001, FLOOR_1=0010, FLOOR_2=0100, FLOOR_3=1000.
  - State enum {IDLE, MOVE_UP, MOVE_DN, DOOR}.
  - One-hot lowest/highest-bit-select functions.
- Sub-module call_sync_edge: 4-bit 2-flop synchronizer plus rising-edge detect; parameter WIDTH; same clk/rst_n.

Test Plan:
- Reset, then present_floor=0001, no calls -> requested_floor=0001, pending=0000, busy=0, door_open=0, dir_up=1.
- Car at 0001, press floor 3 (call_btn=1000 for 5 cycles) -> pending=1000 on the 3rd edge, state MOVE_UP, requested_floor=1000. Drive present_floor 0010, 0100, 1000 -> DOOR at 1000, pending=0000, door_open high for 3 ticks, then IDLE.
- Car moving up from 0001 toward 1000; press floor 1 while present_floor=0001 -> requested_floor becomes 0010 next cycle. Car stops at 0010 (DOOR), then resumes MOVE_UP to 1000.
- Car at 0100 in MOVE_UP with pending=1001 -> serves 1000 first, then DOOR exit reverses: MOVE_DN, dir_up=0, requested_floor=0001.
- During DOOR at 0010, press floor 1 after 2 ticks -> counter reloads, door_open lasts 3 more ticks, pending[1] stays 0.
- present_floor=0000 with pending=0100 -> no transition, no clear. rst_n low for one edge mid-MOVE_UP -> pending=0000, requested_floor=0001, state IDLE.
